button_event_reader: RTL and testbench

- Input-side counterpart to the board LED drivers: samples raw push-button pins and synchronises them.
- Debounces each button and produces clean levels plus press, release and long-press pulses.
- Queues encoded events in a small FIFO with a valid/ready handshake, so the top-level logic can read button activity the same way it drives the LEDs.

---
 rtl/button_event_reader.sv | 234 +++++++++++++++++++++++
 tb/tb_button_event_reader.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_reader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// button_event_reader
//
// Samples raw push-button pins, synchronises and debounces them, and turns
// the clean levels into press / release / long-press pulses. Every pulse is
// latched in a pending bit and an arbiter moves the lowest pending event into
// a small show-ahead FIFO that the consumer drains with a valid/ready handshake.
//
// Ports:
//   CLK_12_MHZ     system clock
//   RST_N          asynchronous active-low reset
//   btn_pin        raw asynchronous button pins
//   btn_level      debounced level per button, 1 = pressed
//   press_pulse    1-cycle pulse in the first cycle btn_level is 1
//   release_pulse  1-cycle pulse in the first cycle btn_level is 0 again
//   long_pulse     1-cycle pulse when a hold reaches LONG_PRESS_CYCLES
//   evt_valid      FIFO head valid
//   evt_ready      consumer accepts the head entry
//   evt_btn        button index of the head event
//   evt_type       head event type: 0 press, 1 release, 2 long
//   overflow       sticky: an event was merged into an already pending one
//   overflow_clr   synchronous clear of overflow
//
// Handshake: the head entry is transferred in every cycle where evt_valid and
// evt_ready are both 1; evt_btn/evt_type are stable while evt_valid is held
// without evt_ready, and evt_ready while evt_valid is 0 has no effect.
// -----------------------------------------------------------------------------
module button_event_reader #(
    parameter int NUM_BUTTONS       = 4,
    parameter int ACTIVE_LOW        = 1,
    parameter int DEBOUNCE_CYCLES   = 120000,
    parameter int LONG_PRESS_CYCLES = 12000000,
    parameter int FIFO_DEPTH        = 4,
    localparam int BTN_W            = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1
) (
    input  logic                   CLK_12_MHZ,
    input  logic                   RST_N,
    input  logic [NUM_BUTTONS-1:0] btn_pin,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] press_pulse,
    output logic [NUM_BUTTONS-1:0] release_pulse,
    output logic [NUM_BUTTONS-1:0] long_pulse,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [BTN_W-1:0]       evt_btn,
    output logic [1:0]             evt_type,
    output logic                   overflow,
    input  logic                   overflow_clr
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int NUM_K  = 3 * NUM_BUTTONS;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int ENT_W  = BTN_W + 2;

    localparam logic [NUM_BUTTONS-1:0] IDLE_PIN =
        (ACTIVE_LOW != 0) ? {NUM_BUTTONS{1'b1}} : {NUM_BUTTONS{1'b0}};
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_HIT = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [PTR_W:0]    FIFO_FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    // ---------------- synchroniser ----------------
    logic [NUM_BUTTONS-1:0] sync1;
    logic [NUM_BUTTONS-1:0] sync2;
    logic [NUM_BUTTONS-1:0] pressed_now;

    // Reset to the released pin value so leaving reset never looks like a press.
    always_ff @(posedge CLK_12_MHZ or negedge RST_N) begin
        if (!RST_N) begin
            sync1 <= IDLE_PIN;
            sync2 <= IDLE_PIN;
        end else begin
            sync1 <= btn_pin;
            sync2 <= sync1;
        end
    end

    assign pressed_now = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

    // ---------------- debounce, edge and hold tracking ----------------
    logic [NUM_BUTTONS-1:0] level_q;
    logic [NUM_BUTTONS-1:0] level_d;
    logic [DB_W-1:0]        db_cnt   [NUM_BUTTONS];
    logic [HOLD_W-1:0]      hold_cnt [NUM_BUTTONS];

    always_ff @(posedge CLK_12_MHZ or negedge RST_N) begin
        if (!RST_N) begin
            level_q <= '0;
            level_d <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                db_cnt[i]   <= '0;
                hold_cnt[i] <= '0;
            end
        end else begin
            level_d <= level_q;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                // The counter measures how long the input has disagreed with
                // the accepted level; any agreement restarts the measurement.
                if (pressed_now[i] != level_q[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        level_q[i] <= ~level_q[i];
                        db_cnt[i]  <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end

                // hold_cnt holds the number of earlier pressed cycles, so the
                // count including the current cycle is hold_cnt + 1.
                if (level_q[i]) begin
                    if (hold_cnt[i] != HOLD_MAX) begin
                        hold_cnt[i] <= hold_cnt[i] + HOLD_W'(1);
                    end
                end else begin
                    hold_cnt[i] <= '0;
                end
            end
        end
    end

    assign btn_level = level_q;

    always_comb begin
        press_pulse   = level_q & ~level_d;
        release_pulse = ~level_q & level_d;
        long_pulse    = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            long_pulse[i] = level_q[i] && (hold_cnt[i] == HOLD_HIT);
        end
    end

    // ---------------- pending bits and arbiter ----------------
    logic [NUM_K-1:0] evt_vec;
    logic [NUM_K-1:0] pend;
    logic [NUM_K-1:0] sel_mask;
    logic             sel_valid;
    logic [BTN_W-1:0] sel_btn;
    logic [1:0]       sel_type;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             overflow_set;

    always_comb begin
        evt_vec = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            evt_vec[3*i]     = press_pulse[i];
            evt_vec[3*i + 1] = release_pulse[i];
            evt_vec[3*i + 2] = long_pulse[i];
        end
    end

    // Scanning from the top down lets the lowest set index win.
    always_comb begin
        sel_valid = 1'b0;
        sel_btn   = '0;
        sel_type  = '0;
        for (int b = NUM_BUTTONS - 1; b >= 0; b--) begin
            for (int t = 2; t >= 0; t--) begin
                if (pend[3*b + t]) begin
                    sel_valid = 1'b1;
                    sel_btn   = BTN_W'(b);
                    sel_type  = 2'(t);
                end
            end
        end
    end

    // Isolate the lowest set pending bit.
    assign sel_mask     = pend & (~pend + NUM_K'(1));
    assign fifo_full    = (fifo_cnt == FIFO_FULL_CNT);
    assign push         = sel_valid & ~fifo_full;
    assign pop          = evt_valid & evt_ready;
    assign overflow_set = |(pend & evt_vec);

    always_ff @(posedge CLK_12_MHZ or negedge RST_N) begin
        if (!RST_N) begin
            pend     <= '0;
            overflow <= 1'b0;
        end else begin
            pend <= (pend & ~(push ? sel_mask : '0)) | evt_vec;
            if (overflow_set) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // ---------------- show-ahead FIFO ----------------
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   fifo_cnt;
    logic [ENT_W-1:0] head;

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge CLK_12_MHZ) begin
        if (push) begin
            mem[wr_ptr] <= {sel_btn, sel_type};
        end
    end

    always_ff @(posedge CLK_12_MHZ or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PTR_W + 1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PTR_W + 1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign evt_valid = (fifo_cnt != '0);
    assign evt_btn   = evt_valid ? head[ENT_W-1:2] : '0;
    assign evt_type  = evt_valid ? head[1:0] : 2'b00;

endmodule

// File: tb/tb_button_event_reader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_button_event_reader
//
// Directed bench for button_event_reader with short debounce / long-press
// windows. Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_button_event_reader;

    localparam int NB = 4;

    logic          clk;
    logic          rst_n;
    logic [NB-1:0] btn_pin;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] press_pulse;
    logic [NB-1:0] release_pulse;
    logic [NB-1:0] long_pulse;
    logic          evt_valid;
    logic          evt_ready;
    logic [1:0]    evt_btn;
    logic [1:0]    evt_type;
    logic          overflow;
    logic          overflow_clr;

    int n_checks = 0;
    int n_fail   = 0;

    button_event_reader #(
        .NUM_BUTTONS      (NB),
        .ACTIVE_LOW       (1),
        .DEBOUNCE_CYCLES  (8),
        .LONG_PRESS_CYCLES(32),
        .FIFO_DEPTH       (4)
    ) dut (
        .CLK_12_MHZ   (clk),
        .RST_N        (rst_n),
        .btn_pin      (btn_pin),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_btn      (evt_btn),
        .evt_type     (evt_type),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver helpers ----------------
    // Wait (bounded) until btn_level[idx] equals val; n = negedges waited.
    task automatic wait_level(input int idx, input logic val, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            n++;
            if (btn_level[idx] === val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Wait (bounded) for evt_valid, capture the head and pop it with a 1-cycle ready.
    task automatic pop_event(output logic [3:0] ev, output bit ok);
        ok = 1'b0;
        ev = 4'h0;
        for (int i = 0; i < 20; i++) begin
            if (evt_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            ev        = {evt_btn, evt_type};
            evt_ready = 1'b1;
            @(negedge clk);
            evt_ready = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int activity;
        rst_n        = 1'b0;
        btn_pin      = 4'b1111;
        evt_ready    = 1'b0;
        overflow_clr = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (btn_level !== 4'b0000) begin
            n_fail++; $display("FAIL reset_level: got %b want 0000", btn_level);
        end
        n_checks++;
        if ({press_pulse, release_pulse, long_pulse} !== 12'h000) begin
            n_fail++; $display("FAIL reset_pulses: got %h want 000", {press_pulse, release_pulse, long_pulse});
        end
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", evt_valid);
        end
        n_checks++;
        if ({evt_btn, evt_type} !== 4'h0) begin
            n_fail++; $display("FAIL reset_head: got %h want 0", {evt_btn, evt_type});
        end
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow);
        end

        rst_n    = 1'b1;
        activity = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if ((btn_level | press_pulse | release_pulse | long_pulse) !== 4'b0000 ||
                evt_valid !== 1'b0 || overflow !== 1'b0)
                activity++;
        end
        n_checks++;
        if (activity !== 0) begin
            n_fail++; $display("FAIL idle_activity: got %0d active cycles want 0", activity);
        end
    endtask

    task automatic test_clean_press();
        int n;
        bit ok;
        logic [3:0] ev;
        btn_pin[0] = 1'b0;
        wait_level(0, 1'b1, n, ok);
        // two synchroniser flops plus eight debounce cycles
        n_checks++;
        if (!ok || n !== 10) begin
            n_fail++; $display("FAIL press_latency: got %0d cycles (ok=%0d) want 10", n, ok);
        end
        n_checks++;
        if (press_pulse !== 4'b0001) begin
            n_fail++; $display("FAIL press_pulse_on: got %b want 0001", press_pulse);
        end
        @(negedge clk);
        n_checks++;
        if (press_pulse !== 4'b0000 || evt_valid !== 1'b0) begin
            n_fail++; $display("FAIL press_pulse_off: got pulse=%b valid=%b want 0000/0", press_pulse, evt_valid);
        end
        @(negedge clk);
        n_checks++;
        if (evt_valid !== 1'b1 || {evt_btn, evt_type} !== 4'h0) begin
            n_fail++; $display("FAIL press_event: got valid=%b head=%h want 1/0", evt_valid, {evt_btn, evt_type});
        end
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_fail++; $display("FAIL press_pop: got valid=%b want 0", evt_valid);
        end

        btn_pin[0] = 1'b1;
        wait_level(0, 1'b0, n, ok);
        n_checks++;
        if (!ok || release_pulse !== 4'b0001) begin
            n_fail++; $display("FAIL release_pulse: got %b (ok=%0d) want 0001", release_pulse, ok);
        end
        pop_event(ev, ok);
        n_checks++;
        if (!ok || ev !== 4'h1) begin
            n_fail++; $display("FAIL release_event: got %h (ok=%0d) want 1", ev, ok);
        end
    endtask

    task automatic test_bounce();
        int activity;
        activity = 0;
        for (int c = 0; c < 60; c++) begin
            btn_pin[1] = (c < 30) ? (((c / 3) % 2) == 1) : 1'b1;
            @(negedge clk);
            if (btn_level[1] !== 1'b0 || press_pulse !== 4'b0000 || evt_valid !== 1'b0)
                activity++;
        end
        n_checks++;
        if (activity !== 0) begin
            n_fail++; $display("FAIL bounce_activity: got %0d active cycles want 0", activity);
        end
    endtask

    task automatic test_long_press();
        int press_c;
        int long_c;
        int long_n;
        logic [3:0] got_q[$];
        logic [3:0] exp_q[$];
        press_c = -1;
        long_c  = -1;
        long_n  = 0;
        exp_q   = '{4'h8, 4'hA, 4'h9};
        evt_ready  = 1'b1;
        btn_pin[2] = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (press_pulse[2] === 1'b1 && press_c < 0) press_c = c;
            if (long_pulse[2] === 1'b1) begin
                long_n++;
                if (long_c < 0) long_c = c;
            end
            if (evt_valid === 1'b1) got_q.push_back({evt_btn, evt_type});
            if (c == 39) btn_pin[2] = 1'b1;
        end
        evt_ready = 1'b0;
        n_checks++;
        if (press_c < 0 || long_c < 0 || (long_c - press_c) !== 31) begin
            n_fail++; $display("FAIL long_delay: got press@%0d long@%0d want distance 31", press_c, long_c);
        end
        n_checks++;
        if (long_n !== 1) begin
            n_fail++; $display("FAIL long_count: got %0d want 1", long_n);
        end
        n_checks++;
        if (got_q.size() !== 3) begin
            n_fail++; $display("FAIL long_events: got %0d events want 3", got_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL long_order[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 4'hF, exp_q[i]);
            end
        end
    endtask

    task automatic test_simultaneous();
        int n;
        bit ok;
        logic [3:0] ev;
        logic [3:0] exp_q[$];
        exp_q   = '{4'h0, 4'hC, 4'h1, 4'hD};
        btn_pin = 4'b0110;
        wait_level(0, 1'b1, n, ok);
        n_checks++;
        if (!ok || press_pulse !== 4'b1001) begin
            n_fail++; $display("FAIL sim_press_pulse: got %b (ok=%0d) want 1001", press_pulse, ok);
        end
        for (int i = 0; i < 2; i++) begin
            pop_event(ev, ok);
            n_checks++;
            if (!ok || ev !== exp_q[i]) begin
                n_fail++; $display("FAIL sim_order[%0d]: got %h (ok=%0d) want %h", i, ev, ok, exp_q[i]);
            end
        end
        btn_pin = 4'b1111;
        wait_level(0, 1'b0, n, ok);
        for (int i = 2; i < 4; i++) begin
            pop_event(ev, ok);
            n_checks++;
            if (!ok || ev !== exp_q[i]) begin
                n_fail++; $display("FAIL sim_order[%0d]: got %h (ok=%0d) want %h", i, ev, ok, exp_q[i]);
            end
        end
    endtask

    task automatic test_full_overflow();
        int n;
        bit ok;
        logic [3:0] ev;
        logic [3:0] exp_q[$];
        // FIFO holds p0,p1,r0,r1; pending bits drain in index order afterwards
        exp_q     = '{4'h0, 4'h4, 4'h1, 4'h5, 4'h0, 4'h1, 4'h8, 4'h9};
        evt_ready = 1'b0;

        btn_pin = 4'b1100;
        wait_level(0, 1'b1, n, ok);
        btn_pin = 4'b1111;
        wait_level(0, 1'b0, n, ok);
        repeat (3) @(negedge clk);

        btn_pin[2] = 1'b0;
        wait_level(2, 1'b1, n, ok);
        btn_pin[2] = 1'b1;
        wait_level(2, 1'b0, n, ok);
        repeat (2) @(negedge clk);
        n_checks++;
        if (evt_valid !== 1'b1 || {evt_btn, evt_type} !== 4'h0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL full_hold: got valid=%b head=%h ovf=%b want 1/0/0", evt_valid, {evt_btn, evt_type}, overflow);
        end

        btn_pin[0] = 1'b0;
        wait_level(0, 1'b1, n, ok);
        btn_pin[0] = 1'b1;
        wait_level(0, 1'b0, n, ok);
        @(negedge clk);
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_early: got %b want 0", overflow);
        end
        btn_pin[0] = 1'b0;
        wait_level(0, 1'b1, n, ok);
        btn_pin[0] = 1'b1;
        wait_level(0, 1'b0, n, ok);
        repeat (2) @(negedge clk);
        n_checks++;
        if (overflow !== 1'b1 || evt_valid !== 1'b1 || {evt_btn, evt_type} !== 4'h0) begin
            n_fail++; $display("FAIL ovf_set: got ovf=%b valid=%b head=%h want 1/1/0", overflow, evt_valid, {evt_btn, evt_type});
        end

        for (int i = 0; i < 8; i++) begin
            pop_event(ev, ok);
            n_checks++;
            if (!ok || ev !== exp_q[i]) begin
                n_fail++; $display("FAIL drain[%0d]: got %h (ok=%0d) want %h", i, ev, ok, exp_q[i]);
            end
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (evt_valid !== 1'b0 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL drain_end: got valid=%b ovf=%b want 0/1", evt_valid, overflow);
        end
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n        = 1'b0;
        btn_pin      = 4'b1111;
        evt_ready    = 1'b0;
        overflow_clr = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_simultaneous();
        test_full_overflow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
